common_bus_responder: RTL and testbench

// CPU-facing end of the common-bus arbiter protocol. It accepts ARBOPC/ARBI operations and executes them on main memory.
// The peripheral processor (PP) competes for the same memory port; the two requesters are served round-robin.

---
 rtl/common_bus_responder.sv | 232 +++++++++++++++++++++++
 tb/tb_common_bus_responder.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/common_bus_responder.sv
// common_bus_responder: CPU arbiter-opcode front end sharing one req/ack memory port
// with the peripheral processor, round-robin arbitrated, with per-access ack timeout.
`timescale 1ns/1ps
`default_nettype none

module common_bus_responder #(
  parameter int AW  = 20,
  parameter int TMO = 255
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  // CPU command side
  input  logic          cmd_valid_i,
  input  logic [3:0]    cmd_op_i,
  input  logic [31:0]   cmd_addr_i,
  input  logic [71:0]   cmd_wdata_i,
  output logic          arb_rdy_o,
  output logic          cpu_rvalid_o,
  output logic [71:0]   cpu_rdata_o,
  output logic          arb_err_o,
  // peripheral processor side
  input  logic          pp_req_i,
  input  logic          pp_we_i,
  input  logic [AW-1:0] pp_addr_i,
  input  logic [71:0]   pp_wdata_i,
  output logic          pp_ack_o,
  output logic [71:0]   pp_rdata_o,
  // memory port
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [71:0]   mem_wdata_o,
  input  logic          mem_ack_i,
  input  logic [71:0]   mem_rdata_i
);

  localparam int              CW       = $clog2(TMO + 1);
  localparam logic [CW-1:0]   TMO_LAST = CW'(TMO - 1);

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_READ   = 4'd1;
  localparam logic [3:0] OP_WRITE  = 4'd2;
  localparam logic [3:0] OP_TAS    = 4'd3;
  localparam logic [3:0] OP_CLRERR = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_TASW = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          busy_q, busy_d;
  logic [3:0]    op_q, op_d;
  logic [AW-1:0] caddr_q, caddr_d;
  logic [71:0]   cwdata_q, cwdata_d;
  logic          pp_pend_q, pp_pend_d;
  logic          last_pp_q, last_pp_d;
  logic          gnt_pp_q, gnt_pp_d;
  logic          we_q, we_d;
  logic          rd_q, rd_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [71:0]   wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [71:0]   cpu_rdata_q, cpu_rdata_d;
  logic [71:0]   pp_rdata_q, pp_rdata_d;

  logic mem_req, ack, tmo, err_set, err_clr, accept;
  logic unused_addr_bits;

  assign unused_addr_bits = ^cmd_addr_i[31:AW];

  assign mem_req = (state_q == S_ACC) || (state_q == S_TASW);
  assign ack     = mem_req && mem_ack_i;
  // an ack on the last allowed cycle wins over the timeout
  assign tmo     = mem_req && !mem_ack_i && (cnt_q == TMO_LAST);
  assign accept  = cmd_valid_i && !busy_q;

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    op_d        = op_q;
    caddr_d     = caddr_q;
    cwdata_d    = cwdata_q;
    last_pp_d   = last_pp_q;
    gnt_pp_d    = gnt_pp_q;
    we_d        = we_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    pp_rdata_d  = pp_rdata_q;
    err_set     = 1'b0;
    err_clr     = 1'b0;
    // PP request is sampled so it competes on equal footing with a just-latched CPU command
    pp_pend_d   = pp_req_i && !(gnt_pp_q && (state_q != S_IDLE));

    if (accept) begin
      case (cmd_op_i)
        OP_READ, OP_WRITE, OP_TAS: begin
          busy_d   = 1'b1;
          op_d     = cmd_op_i;
          caddr_d  = cmd_addr_i[AW-1:0];
          cwdata_d = cmd_wdata_i;
        end
        OP_CLRERR: err_clr = 1'b1;
        OP_NOP:    ;
        default:   err_set = 1'b1;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (busy_q && (!pp_pend_q || last_pp_q)) begin
          gnt_pp_d  = 1'b0;
          last_pp_d = 1'b0;
          we_d      = (op_q == OP_WRITE);
          rd_d      = (op_q != OP_WRITE);
          addr_d    = caddr_q;
          wdata_d   = cwdata_q;
          cnt_d     = '0;
          state_d   = S_ACC;
        end else if (pp_pend_q) begin
          gnt_pp_d  = 1'b1;
          last_pp_d = 1'b1;
          we_d      = pp_we_i;
          rd_d      = !pp_we_i;
          addr_d    = pp_addr_i;
          wdata_d   = pp_wdata_i;
          cnt_d     = '0;
          state_d   = S_ACC;
        end
      end
      S_ACC: begin
        cnt_d = cnt_q + 1'b1;
        if (ack) begin
          if (rd_q) begin
            if (gnt_pp_q) pp_rdata_d  = mem_rdata_i;
            else          cpu_rdata_d = mem_rdata_i;
          end
          if (!gnt_pp_q && (op_q == OP_TAS)) begin
            we_d    = 1'b1;
            rd_d    = 1'b0;
            wdata_d = {1'b1, mem_rdata_i[70:0]};
            cnt_d   = '0;
            state_d = S_TASW;
          end else begin
            state_d = S_DONE;
          end
        end else if (tmo) begin
          err_set = 1'b1;
          if (rd_q) begin
            if (gnt_pp_q) pp_rdata_d  = '0;
            else          cpu_rdata_d = '0;
          end
          state_d = S_DONE;
        end
      end
      S_TASW: begin
        cnt_d = cnt_q + 1'b1;
        if (ack) begin
          state_d = S_DONE;
        end else if (tmo) begin
          err_set = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!gnt_pp_q) busy_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      op_q        <= OP_NOP;
      caddr_q     <= '0;
      cwdata_q    <= '0;
      pp_pend_q   <= 1'b0;
      last_pp_q   <= 1'b1;
      gnt_pp_q    <= 1'b0;
      we_q        <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      cpu_rdata_q <= '0;
      pp_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      op_q        <= op_d;
      caddr_q     <= caddr_d;
      cwdata_q    <= cwdata_d;
      pp_pend_q   <= pp_pend_d;
      last_pp_q   <= last_pp_d;
      gnt_pp_q    <= gnt_pp_d;
      we_q        <= we_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      cpu_rdata_q <= cpu_rdata_d;
      pp_rdata_q  <= pp_rdata_d;
    end
  end

  assign arb_rdy_o    = !busy_q;
  assign cpu_rvalid_o = (state_q == S_DONE) && !gnt_pp_q && (op_q != OP_WRITE);
  assign cpu_rdata_o  = cpu_rdata_q;
  assign arb_err_o    = err_q;
  assign pp_ack_o     = (state_q == S_DONE) && gnt_pp_q;
  assign pp_rdata_o   = pp_rdata_q;
  assign mem_req_o    = mem_req;
  assign mem_we_o     = mem_req && we_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_common_bus_responder.sv
// Self-checking bench for common_bus_responder: vector table, directed corner cases,
// and randomized CPU/PP traffic against a word-level memory reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_common_bus_responder;

  localparam int AW  = 20;
  localparam int TMO = 255;
  localparam logic [3:0] NOP = 4'd0, RD = 4'd1, WR = 4'd2, TAS = 4'd3, CLR = 4'd8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic [3:0]    cmd_op;
  logic [31:0]   cmd_addr;
  logic [71:0]   cmd_wdata;
  logic          arb_rdy, cpu_rvalid, arb_err;
  logic [71:0]   cpu_rdata;
  logic          pp_req, pp_we;
  logic [AW-1:0] pp_addr;
  logic [71:0]   pp_wdata;
  logic          pp_ack;
  logic [71:0]   pp_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [71:0]   mem_wdata;
  logic          mem_ack;
  logic [71:0]   mem_rdata;

  always #5 clk = ~clk;

  common_bus_responder #(.AW(AW), .TMO(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_op_i(cmd_op), .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .arb_rdy_o(arb_rdy), .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata), .arb_err_o(arb_err),
    .pp_req_i(pp_req), .pp_we_i(pp_we), .pp_addr_i(pp_addr), .pp_wdata_i(pp_wdata),
    .pp_ack_o(pp_ack), .pp_rdata_o(pp_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  typedef struct { logic we; logic [AW-1:0] addr; logic [71:0] data; } acc_t;
  acc_t        acc_log[$];
  logic [71:0] tbmem [int];
  int          ack_delay = 0;
  logic        ack_en = 1'b1;

  function automatic logic [71:0] rdmem(input int a);
    if (tbmem.exists(a)) return tbmem[a];
    return '0;
  endfunction

  initial begin
    int wcnt;
    acc_t e;
    wcnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (mem_req && ack_en) begin
        if (wcnt == ack_delay) begin
          mem_ack = 1'b1;
          wcnt = 0;
          e.we = mem_we; e.addr = mem_addr; e.data = mem_we ? mem_wdata : rdmem(int'(mem_addr));
          if (mem_we) tbmem[int'(mem_addr)] = mem_wdata;
          else        mem_rdata = e.data;
          acc_log.push_back(e);
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // ---------------- CPU / PP helpers ----------------
  task automatic cpu_cmd(input logic [3:0] op, input logic [31:0] a, input logic [71:0] wd,
                         output logic rv, output logic [71:0] rd, output int lat, output int reqc);
    logic done;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = wd;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rv = 1'b0; rd = '0; lat = 0; reqc = 0; done = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      lat++;
      if (mem_req) reqc++;
      if (cpu_rvalid) begin rv = 1'b1; rd = cpu_rdata; end
      if (arb_rdy) begin done = 1'b1; break; end
    end
    chk("cpu_cmd_completes", done, 1'b1);
  endtask

  task automatic pp_op(input logic we, input logic [AW-1:0] a, input logic [71:0] wd,
                       output logic ok, output logic [71:0] rd);
    @(posedge clk); #1;
    pp_req = 1'b1; pp_we = we; pp_addr = a; pp_wdata = wd;
    ok = 1'b0; rd = '0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (pp_ack) begin ok = 1'b1; rd = pp_rdata; break; end
    end
    @(posedge clk); #1;
    pp_req = 1'b0; pp_we = 1'b0;
  endtask

  // CPU READ and PP read raised in the same cycle; reports who hit memory first
  task automatic arb_round(input logic [AW-1:0] a_cpu, input logic [AW-1:0] a_pp, input string tag);
    logic pp_seen, cpu_done;
    int   n0;
    n0 = acc_log.size();
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = RD; cmd_addr = 32'(a_cpu); cmd_wdata = '0;
    pp_req = 1'b1; pp_we = 1'b0; pp_addr = a_pp;
    pp_seen = 1'b0; cpu_done = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (pp_ack) begin pp_seen = 1'b1; chk({tag, "_pp_rdata"}, pp_rdata, rdmem(int'(a_pp))); end
      if (arb_rdy && i > 0) cpu_done = 1'b1;
      if (pp_seen && cpu_done) break;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (pp_seen) pp_req = 1'b0;
    end
    @(posedge clk); #1;
    pp_req = 1'b0; cmd_valid = 1'b0;
    chk({tag, "_both_done"}, {pp_seen, cpu_done}, 2'b11);
    chk({tag, "_n_acc"}, 72'(acc_log.size() - n0), 72'd2);
    if (acc_log.size() - n0 == 2) begin
      chk({tag, "_first_is_cpu"}, 72'(acc_log[n0].addr), 72'(a_cpu));
      chk({tag, "_second_is_pp"}, 72'(acc_log[n0 + 1].addr), 72'(a_pp));
    end
    chk({tag, "_cpu_rdata"}, cpu_rdata, rdmem(int'(a_cpu)));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [71:0] wd;
    logic        exp_rv;
    logic [71:0] exp_rd;
    logic        exp_err;
    int          exp_acc;
  } vec_t;

  localparam logic [71:0] WA  = 72'h12_0011_2233_4455_6677;
  localparam logic [71:0] WAT = 72'h92_0011_2233_4455_6677;
  localparam logic [71:0] WB  = 72'hFF_8888_9999_AAAA_BBBB;

  vec_t tv[10];

  logic [71:0] ref_mem [8];

  initial begin
    logic        rv, ok;
    logic [71:0] rd, wd, exp;
    int          lat, reqc, n0, sel, ai;

    tv[0] = '{WR,  32'h100, WA,  1'b0, '0,  1'b0, 1};
    tv[1] = '{RD,  32'h100, '0,  1'b1, WA,  1'b0, 1};
    tv[2] = '{TAS, 32'h100, '0,  1'b1, WA,  1'b0, 2};
    tv[3] = '{RD,  32'h100, '0,  1'b1, WAT, 1'b0, 1};
    tv[4] = '{NOP, 32'h100, WB,  1'b0, '0,  1'b0, 0};
    tv[5] = '{4'h7,32'h100, WB,  1'b0, '0,  1'b1, 0};
    tv[6] = '{RD,  32'h100, '0,  1'b1, WAT, 1'b1, 1};
    tv[7] = '{CLR, 32'h0,   '0,  1'b0, '0,  1'b0, 0};
    tv[8] = '{WR,  32'h2,   WB,  1'b0, '0,  1'b0, 1};
    tv[9] = '{RD,  32'h2,   '0,  1'b1, WB,  1'b0, 1};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0;
    pp_req = 1'b0; pp_we = 1'b0; pp_addr = '0; pp_wdata = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arb_rdy", arb_rdy, 1'b1);
    chk("rst_quiet", {cpu_rvalid, arb_err, pp_ack, mem_req, mem_we}, '0);
    chk("rst_data", cpu_rdata | pp_rdata | mem_wdata | 72'(mem_addr), '0);
    rst_n = 1'b1;

    // round-robin: after reset PP was last, so CPU wins each simultaneous round
    tbmem[32'h10] = 72'h01_0000_0000_0000_0010;
    tbmem[32'h20] = 72'h02_0000_0000_0000_0020;
    tbmem[32'h11] = 72'h03_0000_0000_0000_0011;
    tbmem[32'h21] = 72'h04_0000_0000_0000_0021;
    arb_round(20'h10, 20'h20, "arb1");
    arb_round(20'h11, 20'h21, "arb2");

    // READ with ack two cycles after request
    tbmem[32'h123] = 72'hAB_0000_0000_DEAD_BEEF;
    ack_delay = 2;
    cpu_cmd(RD, 32'h0000_0123, '0, rv, rd, lat, reqc);
    chk("read_rvalid", rv, 1'b1);
    chk("read_rdata", rd, 72'hAB_0000_0000_DEAD_BEEF);
    chk("read_req_cycles", 72'(reqc), 72'd3);
    chk("read_busy_then_rdy", 72'(lat), 72'd6);

    // latency with ack in first ACC cycle
    ack_delay = 0;
    cpu_cmd(RD, 32'h0000_0123, '0, rv, rd, lat, reqc);
    chk("latency_4", 72'(lat), 72'd4);

    // TAS
    tbmem[32'h200] = 72'h01_CAFE_F00D_1234_5678;
    n0 = acc_log.size();
    cpu_cmd(TAS, 32'h200, '0, rv, rd, lat, reqc);
    chk("tas_rdata_old", rd, 72'h01_CAFE_F00D_1234_5678);
    chk("tas_n_acc", 72'(acc_log.size() - n0), 72'd2);
    if (acc_log.size() - n0 == 2) begin
      chk("tas_first_read", acc_log[n0].we, 1'b0);
      chk("tas_second_write", {acc_log[n0 + 1].we, acc_log[n0 + 1].data}, {1'b1, 72'h81_CAFE_F00D_1234_5678});
    end

    // vector table
    for (int i = 0; i < 10; i++) begin
      ack_delay = i % 3;
      n0 = acc_log.size();
      cpu_cmd(tv[i].op, tv[i].addr, tv[i].wd, rv, rd, lat, reqc);
      chk($sformatf("tv%0d_rvalid", i), rv, tv[i].exp_rv);
      if (tv[i].exp_rv) chk($sformatf("tv%0d_rdata", i), rd, tv[i].exp_rd);
      chk($sformatf("tv%0d_err", i), arb_err, tv[i].exp_err);
      chk($sformatf("tv%0d_n_acc", i), 72'(acc_log.size() - n0), 72'(tv[i].exp_acc));
    end

    // commands while busy are ignored
    tbmem[32'h300] = 72'h55_0000_0000_0000_0300;
    ack_delay = 5;
    n0 = acc_log.size();
    @(posedge clk); #1; cmd_valid = 1'b1; cmd_op = RD; cmd_addr = 32'h300;
    @(posedge clk); #1; cmd_op = 4'h7;
    @(posedge clk); #1; cmd_op = WR; cmd_wdata = 72'hEE_EEEE_EEEE_EEEE_EEEE;
    @(posedge clk); #1; cmd_valid = 1'b0;
    rv = 1'b0; rd = '0; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cpu_rvalid) begin rv = 1'b1; rd = cpu_rdata; end
      if (arb_rdy) begin ok = 1'b1; break; end
    end
    chk("busy_completes", ok, 1'b1);
    chk("busy_rdata", rd, 72'h55_0000_0000_0000_0300);
    chk("busy_no_err", arb_err, 1'b0);
    chk("busy_n_acc", 72'(acc_log.size() - n0), 72'd1);
    chk("busy_mem_untouched", rdmem(32'h300), 72'h55_0000_0000_0000_0300);

    // timeout
    ack_en = 1'b0;
    cpu_cmd(RD, 32'h5, '0, rv, rd, lat, reqc);
    chk("tmo_req_cycles", 72'(reqc), 72'(TMO));
    chk("tmo_err", arb_err, 1'b1);
    chk("tmo_rvalid", rv, 1'b1);
    chk("tmo_rdata_zero", cpu_rdata, '0);
    cpu_cmd(CLR, 32'h0, '0, rv, rd, lat, reqc);
    chk("clrerr", arb_err, 1'b0);

    // ack on the exact timeout cycle succeeds
    ack_en = 1'b1;
    ack_delay = TMO - 1;
    tbmem[32'h6] = 72'h77_1111_2222_3333_4444;
    cpu_cmd(RD, 32'h6, '0, rv, rd, lat, reqc);
    chk("tmo_edge_req_cycles", 72'(reqc), 72'(TMO));
    chk("tmo_edge_no_err", arb_err, 1'b0);
    chk("tmo_edge_rdata", rd, 72'h77_1111_2222_3333_4444);

    // randomized traffic against a word-level reference
    for (int i = 0; i < 8; i++) begin
      wd = {8'($urandom), $urandom, $urandom};
      tbmem[32'h40 + i] = wd;
      ref_mem[i] = wd;
    end
    for (int k = 0; k < 40; k++) begin
      sel = int'($urandom_range(0, 4));
      ai  = int'($urandom_range(0, 7));
      wd  = {8'($urandom), $urandom, $urandom};
      ack_delay = int'($urandom_range(0, 3));
      case (sel)
        0: begin
          cpu_cmd(RD, 32'h40 + ai, '0, rv, rd, lat, reqc);
          chk($sformatf("rnd%0d_cpu_read", k), {rv, rd}, {1'b1, ref_mem[ai]});
        end
        1: begin
          cpu_cmd(WR, 32'h40 + ai, wd, rv, rd, lat, reqc);
          chk($sformatf("rnd%0d_cpu_write_norv", k), rv, 1'b0);
          ref_mem[ai] = wd;
        end
        2: begin
          cpu_cmd(TAS, 32'h40 + ai, '0, rv, rd, lat, reqc);
          chk($sformatf("rnd%0d_cpu_tas", k), {rv, rd}, {1'b1, ref_mem[ai]});
          exp = ref_mem[ai];
          exp[71] = 1'b1;
          ref_mem[ai] = exp;
        end
        3: begin
          pp_op(1'b0, AW'(32'h40 + ai), '0, ok, rd);
          chk($sformatf("rnd%0d_pp_read", k), {ok, rd}, {1'b1, ref_mem[ai]});
        end
        default: begin
          pp_op(1'b1, AW'(32'h40 + ai), wd, ok, rd);
          chk($sformatf("rnd%0d_pp_write_ack", k), ok, 1'b1);
          ref_mem[ai] = wd;
        end
      endcase
    end
    for (int i = 0; i < 8; i++) begin
      cpu_cmd(RD, 32'h40 + i, '0, rv, rd, lat, reqc);
      chk($sformatf("rnd_final_%0d", i), rd, ref_mem[i]);
    end
    chk("rnd_no_err", arb_err, 1'b0);

    // asynchronous reset in the middle of an access
    ack_en = 1'b0;
    @(posedge clk); #1; cmd_valid = 1'b1; cmd_op = RD; cmd_addr = 32'h7;
    @(posedge clk); #1; cmd_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) begin ok = 1'b1; break; end
    end
    chk("rst_mid_reached_acc", ok, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_req_low", mem_req, 1'b0);
    chk("rst_mid_rdy_high", arb_rdy, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    ack_en = 1'b1;
    ack_delay = 1;
    tbmem[32'h7] = 72'h3C_0000_1234_0000_5678;
    cpu_cmd(RD, 32'h7, '0, rv, rd, lat, reqc);
    chk("post_rst_read", {rv, rd}, {1'b1, 72'h3C_0000_1234_0000_5678});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
